// File: rtl/sram_extern_ctrl_pkg.sv
// Shared types and helpers for the external async SRAM controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sram_extern_ctrl_pkg;

    // One-hot FSM encoding: each strobe decodes from a single state bit
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_ACCESS = 5'b00100,
        ST_DONE   = 5'b01000,
        ST_TURN   = 5'b10000
    } state_t;

    // Wait/turnaround counters cover the 1..15 access-cycle range
    localparam int WCNT_W = 4;

    // Address bits appended for the beat index (0 when one beat per bus word)
    function automatic int beat_addr_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 0;
    endfunction

    // Storage width of the beat register; kept at least 1 bit so it is declarable
    function automatic int beat_reg_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/sram_extern_ctrl_if.sv
// SoC bus slave port of the SRAM controller: request, write data, read data, stall.
// Latency: none (wiring only).
// Backpressure: wait_bus stalls the master, which holds its request while it is high.
interface sram_extern_ctrl_if #(
    parameter int BUS_AW = 10,
    parameter int BUS_DW = 32
);
    logic [BUS_AW-1:0]   address_bus;
    logic [BUS_DW/8-1:0] byteena_bus;
    logic [BUS_DW-1:0]   data_bus;
    logic                wren_bus;
    logic                ce_bus;
    logic [BUS_DW-1:0]   q_bus;
    logic                wait_bus;

    modport master (
        output address_bus, byteena_bus, data_bus, wren_bus, ce_bus,
        input  q_bus, wait_bus
    );

    modport slave (
        input  address_bus, byteena_bus, data_bus, wren_bus, ce_bus,
        output q_bus, wait_bus
    );
endinterface

// File: rtl/sram_ext_lane_mux.sv
// Selects the write-data/byte-enable lane for the current beat and flags live beats.
// Latency: purely combinational.
// Backpressure: none; follows the beat index driven by the controller FSM.
module sram_ext_lane_mux #(
    parameter int BUS_DW = 32,
    parameter int RAM_DW = 16,
    parameter int BIW    = 1
) (
    input  logic [BIW-1:0]               i_beat,
    input  logic [BUS_DW-1:0]            i_data,
    input  logic [BUS_DW/8-1:0]          i_byteena,
    input  logic                         i_wren,
    output logic [RAM_DW-1:0]            o_data,
    output logic [RAM_DW/8-1:0]          o_byteena,
    output logic [BUS_DW/RAM_DW-1:0]     o_beat_act,
    output logic [BUS_DW/RAM_DW-1:0]     o_rd_en
);
    localparam int RATIO = BUS_DW / RAM_DW;
    localparam int BE_W  = RAM_DW / 8;

    // Lane k carries bus bits [k*RAM_DW +: RAM_DW]; writes with an empty byte mask are dead beats
    always_comb begin
        o_data     = '0;
        o_byteena  = '0;
        o_beat_act = '0;
        o_rd_en    = '0;
        for (int k = 0; k < RATIO; k++) begin
            o_beat_act[k] = !i_wren || (|i_byteena[k*BE_W +: BE_W]);
            if (i_beat == BIW'(k)) begin
                o_data     = i_data[k*RAM_DW +: RAM_DW];
                o_byteena  = i_byteena[k*BE_W +: BE_W];
                o_rd_en[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram_extern_ctrl.sv
// Async SRAM controller: one bus access -> BUS_DW/RAM_DW SETUP+ACCESS beats; SRAM_EXT_RUNTIME_WS_EN adds i_ws_cfg.
// Latency: DONE at 1 + N*(1+WAIT) cycles after acceptance (N = executed beats), then TURN_CYC idle cycles.
// Backpressure: wait_bus = ce_bus except in DONE; the request must stay stable while stalled.
module sram_extern_ctrl
    import sram_extern_ctrl_pkg::*;
#(
    parameter  int BUS_AW   = 10,
    parameter  int BUS_DW   = 32,
    parameter  int RAM_DW   = 16,
    parameter  int WAIT_CYC = 2,
    parameter  int TURN_CYC = 1,
    localparam int RATIO    = BUS_DW / RAM_DW,
    localparam int AEXT     = beat_addr_w(RATIO),
    localparam int BIW      = beat_reg_w(RATIO)
) (
    input  logic                     clock,
    input  logic                     rst,
`ifdef SRAM_EXT_RUNTIME_WS_EN
    input  logic [3:0]               i_ws_cfg,
`endif
    sram_extern_ctrl_if.slave        bus,
    output logic [BUS_AW+AEXT-1:0]   o_address_ram,
    output logic [RAM_DW/8-1:0]      o_byteena_ram,
    output logic [RAM_DW-1:0]        o_data_ram,
    output logic                     o_data_oe_tri,
    output logic                     o_wren_ram,
    output logic                     o_ce_ram,
    output logic                     o_oe_ram,
    input  logic [RAM_DW-1:0]        i_q_ram
);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYC - 1);
    localparam logic [WCNT_W-1:0] TURN_LAST = (TURN_CYC > 0) ? WCNT_W'(TURN_CYC - 1) : '0;

    state_t              r_state, w_state_nxt;
    logic [BIW-1:0]      r_beat, w_beat_nxt;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic [BUS_DW-1:0]   r_q;
    logic                w_accept;
    logic                w_sample;
    logic                w_srch_found;
    logic [BIW-1:0]      w_srch_beat;
    logic [WCNT_W-1:0]   w_ws_last;
    logic [RATIO-1:0]    w_beat_act;
    logic [RATIO-1:0]    w_rd_en;

    sram_ext_lane_mux #(
        .BUS_DW (BUS_DW),
        .RAM_DW (RAM_DW),
        .BIW    (BIW)
    ) u_lane_mux (
        .i_beat     (r_beat),
        .i_data     (bus.data_bus),
        .i_byteena  (bus.byteena_bus),
        .i_wren     (bus.wren_bus),
        .o_data     (o_data_ram),
        .o_byteena  (o_byteena_ram),
        .o_beat_act (w_beat_act),
        .o_rd_en    (w_rd_en)
    );

`ifdef SRAM_EXT_RUNTIME_WS_EN
    logic [WCNT_W-1:0] r_ws;

    // Latch the per-transaction access length when a request is accepted; 0 means 1
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_ws <= 4'd1;
        end else if (w_accept) begin
            r_ws <= (i_ws_cfg == 4'd0) ? 4'd1 : i_ws_cfg;
        end
    end

    assign w_ws_last = r_ws - 4'd1;
`else
    assign w_ws_last = WAIT_LAST;
`endif

    // Lowest live beat at or above the search start: 0 on acceptance, beat+1 after an ACCESS
    always_comb begin
        int start;
        start        = (r_state == ST_ACCESS) ? int'(r_beat) + 1 : 0;
        w_srch_found = 1'b0;
        w_srch_beat  = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (w_beat_act[k] && (k >= start)) begin
                w_srch_found = 1'b1;
                w_srch_beat  = BIW'(k);
            end
        end
    end

    // FSM next state, beat and wait counter; the last TURN cycle may accept the next request directly
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_wcnt_nxt  = r_wcnt;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.ce_bus;
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_wcnt_nxt  = '0;
            end
            ST_ACCESS: begin
                if (r_wcnt == w_ws_last) begin
                    w_sample = !bus.wren_bus;
                    if (w_srch_found) begin
                        w_state_nxt = ST_SETUP;
                        w_beat_nxt  = w_srch_beat;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_beat_nxt  = '0;
                    end
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_beat_nxt  = '0;
                w_wcnt_nxt  = '0;
                w_state_nxt = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
            end
            ST_TURN: begin
                if (r_wcnt == TURN_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_accept    = bus.ce_bus;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A write with no enabled bytes has no beats and completes straight away
        if (w_accept) begin
            if (w_srch_found) begin
                w_state_nxt = ST_SETUP;
                w_beat_nxt  = w_srch_beat;
            end else begin
                w_state_nxt = ST_DONE;
                w_beat_nxt  = '0;
            end
        end
    end

    // State, beat index and wait counter registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Capture SRAM read data into the lane of the current beat on its last ACCESS cycle
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_sample) begin
            for (int k = 0; k < RATIO; k++) begin
                if (w_rd_en[k]) begin
                    r_q[k*RAM_DW +: RAM_DW] <= i_q_ram;
                end
            end
        end
    end

    // Strobes decode from state so reset removes them asynchronously
    always_comb begin
        o_ce_ram      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        o_oe_ram      = (r_state == ST_ACCESS) && !bus.wren_bus;
        o_wren_ram    = (r_state == ST_ACCESS) && bus.wren_bus;
        o_data_oe_tri = o_ce_ram && bus.wren_bus;
        bus.wait_bus  = bus.ce_bus && (r_state != ST_DONE);
        bus.q_bus     = r_q;
    end

    generate
        if (AEXT > 0) begin : g_addr_beat
            assign o_address_ram = {bus.address_bus, r_beat};
        end else begin : g_addr_flat
            assign o_address_ram = bus.address_bus;
        end
    endgenerate

endmodule

// File: tb/tb_sram_extern_ctrl.sv
module tb_sram_extern_ctrl;
    localparam int BUS_AW = 10, BUS_DW = 32, RAM_DW = 16, WAIT_CYC = 2, TURN_CYC = 1;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    sram_extern_ctrl_if #(.BUS_AW(BUS_AW), .BUS_DW(BUS_DW)) bus();

    logic [10:0] address_ram;
    logic [1:0]  byteena_ram;
    logic [15:0] data_ram, q_ram;
    logic        data_oe_tri, wren_ram, ce_ram, oe_ram;
`ifdef SRAM_EXT_RUNTIME_WS_EN
    logic [3:0]  ws_cfg = 4'd2;
`endif

    sram_extern_ctrl #(
        .BUS_AW(BUS_AW), .BUS_DW(BUS_DW), .RAM_DW(RAM_DW),
        .WAIT_CYC(WAIT_CYC), .TURN_CYC(TURN_CYC)
    ) dut (
        .clock         (clock),
        .rst           (rst),
`ifdef SRAM_EXT_RUNTIME_WS_EN
        .i_ws_cfg      (ws_cfg),
`endif
        .bus           (bus),
        .o_address_ram (address_ram),
        .o_byteena_ram (byteena_ram),
        .o_data_ram    (data_ram),
        .o_data_oe_tri (data_oe_tri),
        .o_wren_ram    (wren_ram),
        .o_ce_ram      (ce_ram),
        .o_oe_ram      (oe_ram),
        .i_q_ram       (q_ram)
    );

    // Async SRAM model: reads while oe is high, byte-masked write on each strobed edge
    logic [15:0] mem [0:2047];
    assign q_ram = oe_ram ? mem[address_ram] : 16'h0000;
    always @(posedge clock) begin
        if (ce_ram && wren_ram) begin
            if (byteena_ram[0]) mem[address_ram][7:0]  = data_ram[7:0];
            if (byteena_ram[1]) mem[address_ram][15:8] = data_ram[15:8];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    // Drive one transaction and count strobe cycles until wait_bus drops (cycle 0 = request seen in IDLE)
    task automatic do_txn(input logic wr, input logic [9:0] addr, input logic [3:0] be,
                          input logic [31:0] dat, output int done_cyc, output int oe_cnt,
                          output int we_cnt, output int ce_cnt,
                          output logic [10:0] we_addr, output logic [1:0] we_be);
        @(posedge clock); #1;
        bus.wren_bus = wr; bus.address_bus = addr; bus.byteena_bus = be;
        bus.data_bus = dat; bus.ce_bus = 1'b1;
        done_cyc = -1; oe_cnt = 0; we_cnt = 0; ce_cnt = 0; we_addr = '0; we_be = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clock); #1;
            if (!bus.wait_bus) begin
                done_cyc = c;
                break;
            end
            if (oe_ram) oe_cnt++;
            if (ce_ram) ce_cnt++;
            if (wren_ram) begin
                we_cnt++;
                we_addr = address_ram;
                we_be   = byteena_ram;
            end
        end
        if (done_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL txn_timeout: no completion within 200 cycles, addr=%0d", addr);
        end
        @(posedge clock); #1;
        bus.ce_bus = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if ({wren_ram, ce_ram, oe_ram, data_oe_tri} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {wren_ram, ce_ram, oe_ram, data_oe_tri}); end
        n_tests++; if (bus.q_bus !== 32'h0) begin
            n_fail++; $display("FAIL reset_q: got %h want 00000000", bus.q_bus); end
        bus.ce_bus = 1'b1; #1;
        n_tests++; if (bus.wait_bus !== 1'b1) begin
            n_fail++; $display("FAIL reset_wait_hi: got %b want 1", bus.wait_bus); end
        bus.ce_bus = 1'b0; #1;
        n_tests++; if (bus.wait_bus !== 1'b0) begin
            n_fail++; $display("FAIL reset_wait_lo: got %b want 0", bus.wait_bus); end
        @(posedge clock); #1; rst = 1'b0;
    endtask

    task automatic test_read();
        int d, oe, we, ce; logic [10:0] wa; logic [1:0] wb; logic [31:0] e;
        mem[0] = 16'h1234; mem[1] = 16'hABCD;
        exp_q.push_back(32'hABCD1234);
        do_txn(1'b0, 10'd0, 4'hF, 32'h0, d, oe, we, ce, wa, wb);
        e = exp_q.pop_front();
        n_tests++; if (bus.q_bus !== e) begin
            n_fail++; $display("FAIL read_q: got %h want %h", bus.q_bus, e); end
        n_tests++; if (d != 7) begin
            n_fail++; $display("FAIL read_done_cycle: got %0d want 7", d); end
        n_tests++; if (oe != 4 || we != 0) begin
            n_fail++; $display("FAIL read_strobes: oe=%0d we=%0d want 4/0", oe, we); end
    endtask

    task automatic test_write();
        int d, oe, we, ce; logic [10:0] wa; logic [1:0] wb;
        do_txn(1'b1, 10'd0, 4'hF, 32'hDEADBEEF, d, oe, we, ce, wa, wb);
        n_tests++; if (d != 7) begin
            n_fail++; $display("FAIL write_done_cycle: got %0d want 7", d); end
        n_tests++; if (we != 4 || oe != 0) begin
            n_fail++; $display("FAIL write_strobes: we=%0d oe=%0d want 4/0", we, oe); end
        n_tests++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
            n_fail++; $display("FAIL write_mem: got %h %h want BEEF DEAD", mem[1], mem[0]); end
    endtask

    task automatic test_skip_beats();
        int d, oe, we, ce; logic [10:0] wa; logic [1:0] wb;
        mem[2] = 16'h1111; mem[3] = 16'h0000; mem[4] = 16'hAAAA;
        do_txn(1'b1, 10'd1, 4'hC, 32'h12345678, d, oe, we, ce, wa, wb);
        n_tests++; if (d != 4) begin
            n_fail++; $display("FAIL skip_hi_done: got %0d want 4", d); end
        n_tests++; if (wa !== 11'd3 || wb !== 2'b11 || we != 2) begin
            n_fail++; $display("FAIL skip_hi_lane: addr=%0d be=%b we=%0d want 3/11/2", wa, wb, we); end
        n_tests++; if (mem[3] !== 16'h1234 || mem[2] !== 16'h1111) begin
            n_fail++; $display("FAIL skip_hi_mem: got %h %h want 1234 1111", mem[3], mem[2]); end
        do_txn(1'b1, 10'd2, 4'h1, 32'h00000055, d, oe, we, ce, wa, wb);
        n_tests++; if (d != 4 || wa !== 11'd4 || wb !== 2'b01) begin
            n_fail++; $display("FAIL skip_lo: done=%0d addr=%0d be=%b want 4/4/01", d, wa, wb); end
        n_tests++; if (mem[4] !== 16'hAA55) begin
            n_fail++; $display("FAIL skip_lo_mem: got %h want AA55", mem[4]); end
        do_txn(1'b1, 10'd2, 4'h0, 32'hFFFFFFFF, d, oe, we, ce, wa, wb);
        n_tests++; if (d != 1 || ce != 0 || we != 0) begin
            n_fail++; $display("FAIL skip_all: done=%0d ce=%0d we=%0d want 1/0/0", d, ce, we); end
    endtask

    task automatic test_back_to_back();
        int c, d1, s2, d2; logic gap_ok; logic [31:0] e;
        mem[10] = 16'h1111; mem[11] = 16'h2222; mem[12] = 16'h3333; mem[13] = 16'h4444;
        @(posedge clock); #1;
        bus.wren_bus = 1'b0; bus.address_bus = 10'd5; bus.byteena_bus = 4'hF; bus.ce_bus = 1'b1;
        exp_q.push_back(32'h22221111);
        d1 = -1; c = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock); #1; c++;
            if (!bus.wait_bus) begin d1 = c; break; end
        end
        e = exp_q.pop_front();
        n_tests++; if (d1 != 7 || bus.q_bus !== e) begin
            n_fail++; $display("FAIL b2b_first: done=%0d q=%h want 7 %h", d1, bus.q_bus, e); end
        gap_ok = !oe_ram;
        @(posedge clock); #1; c++;
        bus.address_bus = 10'd6;
        exp_q.push_back(32'h44443333);
        s2 = -1; d2 = -1;
        for (int k = 0; k < 200; k++) begin
            if (s2 < 0 && ce_ram) s2 = c;
            if (s2 < 0 && oe_ram) gap_ok = 1'b0;
            if (!bus.wait_bus) begin d2 = c; break; end
            @(posedge clock); #1; c++;
        end
        e = exp_q.pop_front();
        @(posedge clock); #1; bus.ce_bus = 1'b0;
        n_tests++; if (s2 != d1 + 2 || !gap_ok) begin
            n_fail++; $display("FAIL b2b_setup_gap: setup=%0d gap_ok=%b want %0d/1", s2, gap_ok, d1 + 2); end
        n_tests++; if (d2 != d1 + 8 || bus.q_bus !== e) begin
            n_fail++; $display("FAIL b2b_second: done=%0d q=%h want %0d %h", d2, bus.q_bus, d1 + 8, e); end
    endtask

    task automatic test_reset_mid();
        int d, oe, we, ce; logic [10:0] wa; logic [1:0] wb; logic [31:0] e;
        mem[40] = 16'h7777; mem[41] = 16'h8888;
        @(posedge clock); #1;
        bus.wren_bus = 1'b1; bus.address_bus = 10'd20; bus.byteena_bus = 4'hF;
        bus.data_bus = 32'h01020304; bus.ce_bus = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_tests++; if (wren_ram !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre_access: wren=%b want 1", wren_ram); end
        #2; rst = 1'b1; #1;
        n_tests++; if ({wren_ram, ce_ram, data_oe_tri} !== 3'b000 || bus.q_bus !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_strobes: wr/ce/oe_tri=%b q=%h want 000 0", {wren_ram, ce_ram, data_oe_tri}, bus.q_bus); end
        n_tests++; if (bus.wait_bus !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_idle_wait: got %b want 1", bus.wait_bus); end
        bus.ce_bus = 1'b0;
        @(posedge clock); #1;
        n_tests++; if (mem[40] !== 16'h7777) begin
            n_fail++; $display("FAIL rstmid_no_write: got %h want 7777", mem[40]); end
        rst = 1'b0;
        exp_q.push_back(32'h88887777);
        do_txn(1'b0, 10'd20, 4'hF, 32'h0, d, oe, we, ce, wa, wb);
        e = exp_q.pop_front();
        n_tests++; if (d != 7 || bus.q_bus !== e) begin
            n_fail++; $display("FAIL rstmid_recover: done=%0d q=%h want 7 %h", d, bus.q_bus, e); end
    endtask

    task automatic test_random();
        int d, oe, we, ce, nb; logic [10:0] wa; logic [1:0] wb;
        logic [31:0] full, nd, e, got; logic [3:0] be; logic [9:0] addr;
        for (int i = 0; i < 4; i++) begin
            addr = 10'(100 + i * 3);
            full = $urandom; nd = $urandom; be = 4'($urandom_range(0, 15));
            do_txn(1'b1, addr, 4'hF, full, d, oe, we, ce, wa, wb);
            do_txn(1'b1, addr, be, nd, d, oe, we, ce, wa, wb);
            e = full;
            for (int b = 0; b < 4; b++) if (be[b]) e[b*8 +: 8] = nd[b*8 +: 8];
            nb = int'(|be[1:0]) + int'(|be[3:2]);
            n_tests++; if (d != 1 + nb * 3) begin
                n_fail++; $display("FAIL rand_done[%0d]: be=%h got %0d want %0d", i, be, d, 1 + nb * 3); end
            exp_q.push_back(e);
            do_txn(1'b0, addr, 4'hF, 32'h0, d, oe, we, ce, wa, wb);
            got = bus.q_bus; e = exp_q.pop_front();
            n_tests++; if (got !== e) begin
                n_fail++; $display("FAIL rand_read[%0d]: got %h want %h", i, got, e); end
        end
    endtask

`ifdef SRAM_EXT_RUNTIME_WS_EN
    task automatic test_runtime_ws();
        int d, oe, we, ce; logic [10:0] wa; logic [1:0] wb; logic [31:0] e;
        ws_cfg = 4'd4;
        exp_q.push_back(32'hDEADBEEF);
        do_txn(1'b0, 10'd0, 4'hF, 32'h0, d, oe, we, ce, wa, wb);
        e = exp_q.pop_front();
        n_tests++; if (d != 11 || oe != 8 || bus.q_bus !== e) begin
            n_fail++; $display("FAIL ws4: done=%0d oe=%0d q=%h want 11/8/%h", d, oe, bus.q_bus, e); end
        ws_cfg = 4'd0;
        do_txn(1'b0, 10'd0, 4'hF, 32'h0, d, oe, we, ce, wa, wb);
        n_tests++; if (d != 5 || oe != 2) begin
            n_fail++; $display("FAIL ws0: done=%0d oe=%0d want 5/2", d, oe); end
        ws_cfg = 4'd2;
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        bus.address_bus = '0; bus.byteena_bus = '0; bus.data_bus = '0;
        bus.wren_bus = 1'b0; bus.ce_bus = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_skip_beats();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SRAM_EXT_RUNTIME_WS_EN
        test_runtime_ws();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
